// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared mode constants, snapshot state type and saturating adder
package counters_pkg;

    localparam logic CNT_MODE_WRAP = 1'b0;
    localparam logic CNT_MODE_SAT  = 1'b1;

    localparam int CNT_MAX_W = 64;
    localparam int CNT_IDX_W = $clog2(CNT_MAX_W + 1);

    typedef enum logic {
        SNAP_EMPTY = 1'b0,
        SNAP_FULL  = 1'b1
    } snap_state_t;

    // Returns the carry at bit w and the w-bit result below it; upper bits are zero.
    function automatic logic [CNT_MAX_W:0] sat_add(
        input logic [CNT_MAX_W-1:0] a,
        input logic [CNT_MAX_W-1:0] b,
        input logic                 sat,
        input logic [CNT_IDX_W-1:0] w
    );
        logic [CNT_MAX_W:0] sum;
        logic [CNT_MAX_W:0] mask;
        logic               carry;
        mask  = ({{CNT_MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
        sum   = {1'b0, a} + {1'b0, b};
        carry = sum[w];
        sat_add    = (sat == CNT_MODE_SAT && carry) ? mask : (sum & mask);
        sat_add[w] = carry;
    endfunction

endpackage

// File: rtl/counter_lane.sv
// rtl/counter_lane.sv - one counter channel with overflow pulse and sticky flag
module counter_lane
    import counters_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] inc,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             sticky,
    output logic             sticky_nxt
);

    logic [CNT_MAX_W:0] add_res;
    logic               carry;
    logic [WIDTH-1:0]   add_val;
    logic               ovf_set;
    logic               unused_add;

    assign add_res    = sat_add(CNT_MAX_W'(count), CNT_MAX_W'(inc), sat, CNT_IDX_W'(WIDTH));
    assign carry      = add_res[WIDTH];
    assign add_val    = add_res[WIDTH-1:0];
    assign unused_add = ^add_res;

    assign ovf_set    = en & ~clr & ~load & carry;
    // A new carry beats any clear landing on the same edge.
    assign sticky_nxt = ovf_set | (sticky & ~clr & ~sticky_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            if (clr) begin
                count <= '0;
            end else if (load) begin
                count <= load_val;
            end else if (en) begin
                count <= add_val;
            end
            overflow <= ovf_set;
            sticky   <= sticky_nxt;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of counter lanes with overflow summary and snapshot buffer
module counter_bank
    import counters_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [NCH-1:0]       sat_mode,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic [NCH-1:0]       clr,
    input  logic                 sticky_clr,
    output logic [NCH*WIDTH-1:0] countval,
    output logic [NCH-1:0]       overflow,
    output logic [NCH-1:0]       ovf_sticky,
    output logic                 any_ovf,
    input  logic                 snap_req,
    output logic                 snap_valid,
    input  logic                 snap_ready,
    output logic [NCH*WIDTH-1:0] snap_data,
    output logic                 snap_drop
);

    logic [NCH-1:0] sticky_nxt;
    snap_state_t    snap_state;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        counter_lane #(.WIDTH(WIDTH)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en         (en[i]),
            .inc        (data_in[i*WIDTH +: WIDTH]),
            .sat        (sat_mode[i]),
            .load       (load[i]),
            .load_val   (load_val[i*WIDTH +: WIDTH]),
            .clr        (clr[i]),
            .sticky_clr (sticky_clr),
            .count      (countval[i*WIDTH +: WIDTH]),
            .overflow   (overflow[i]),
            .sticky     (ovf_sticky[i]),
            .sticky_nxt (sticky_nxt[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_ovf <= 1'b0;
        end else begin
            any_ovf <= |sticky_nxt;
        end
    end

    assign snap_valid = (snap_state == SNAP_FULL);

    // Captures take the pre-update countval present at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_state <= SNAP_EMPTY;
            snap_data  <= '0;
            snap_drop  <= 1'b0;
        end else begin
            snap_drop <= 1'b0;
            case (snap_state)
                SNAP_EMPTY: begin
                    if (snap_req) begin
                        snap_data  <= countval;
                        snap_state <= SNAP_FULL;
                    end
                end
                SNAP_FULL: begin
                    if (snap_ready) begin
                        if (snap_req) begin
                            snap_data <= countval;
                        end else begin
                            snap_state <= SNAP_EMPTY;
                        end
                    end else if (snap_req) begin
                        snap_drop <= 1'b1;
                    end
                end
                default: snap_state <= SNAP_EMPTY;
            endcase
        end
    end

endmodule
